// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and its surroundings:
// lock and software request in, sequenced domain resets and status out.
interface rst_seq_ctrl_if #(
  parameter int NUM_RST = 4
);
  logic               lock_i;
  logic               sw_rst_req;
  logic [NUM_RST-1:0] rst_n_out;
  logic               seq_done;
  logic               busy;
  logic               err_o;

  modport master (
    output lock_i, sw_rst_req,
    input  rst_n_out, seq_done, busy, err_o
  );

  modport slave (
    input  lock_i, sw_rst_req,
    output rst_n_out, seq_done, busy, err_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: waits for a filtered clock lock, then releases NUM_RST
// active-low domain resets in index order. Optional watchdog: RST_SEQ_WDT_EN.
module rst_seq_ctrl #(
  parameter int NUM_RST    = 4,
  parameter int GAP_CYCLES = 16,
  parameter int LOCK_FILT  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int DW = $clog2(GAP_CYCLES) + 1;
  localparam int FW = $clog2(LOCK_FILT) + 1;
  localparam int IW = $clog2(NUM_RST) + 1;

  localparam logic [DW-1:0] GAP_MAX  = DW'(GAP_CYCLES);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RST - 1);

  // A broken configuration is reported on err_o in every build.
  localparam bit PARAM_OK = (NUM_RST >= 1) && (NUM_RST <= 16) && (GAP_CYCLES >= 2) &&
                            (LOCK_FILT >= 1) && (TIMEOUT >= 1);

  typedef enum logic [1:0] {
    HOLD,
    FILTER,
    RELEASE,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [FW-1:0]      filt_q,  filt_d;
  logic [DW-1:0]      gap_q,   gap_d;
  logic [IW-1:0]      idx_q,   idx_d;
  logic [NUM_RST-1:0] rst_n_q, rst_n_d;
  logic               done_q,  done_d;
  logic               busy_q,  busy_d;
  logic               abort;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    state_d = state_q;
    dwell_d = dwell_q;
    filt_d  = filt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    busy_d  = busy_q;

    // A request while already in HOLD lands here too and simply restarts the dwell.
    abort = bus.sw_rst_req || (!bus.lock_i && (state_q == RELEASE || state_q == DONE));

    if (abort) begin
      state_d = HOLD;
      dwell_d = '0;
      filt_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (dwell_q != GAP_MAX) begin
            dwell_d = dwell_q + DW'(1);
            if (dwell_d == GAP_MAX && bus.lock_i) begin
              state_d = FILTER;
              filt_d  = '0;
            end
          end else if (bus.lock_i) begin
            // Dwell already served: this lock sample is the first filter sample.
            if (FILT_MAX == FW'(1)) begin
              state_d = RELEASE;
              filt_d  = '0;
              gap_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = FILTER;
              filt_d  = FW'(1);
            end
          end
        end

        FILTER: begin
          if (!bus.lock_i) begin
            state_d = HOLD;
            filt_d  = '0;
          end else if (filt_q + FW'(1) == FILT_MAX) begin
            state_d = RELEASE;
            filt_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
          end else begin
            filt_d = filt_q + FW'(1);
          end
        end

        RELEASE: begin
          if (gap_q + DW'(1) == GAP_MAX) begin
            gap_d = '0;
            for (int k = 0; k < NUM_RST; k++) begin
              if (idx_q == IW'(k)) rst_n_d[k] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            gap_d = gap_q + DW'(1);
          end
        end

        DONE: begin
          state_d = DONE;
        end

        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it only takes effect at the next posedge.
    if (rst) begin
      state_q <= HOLD;
      dwell_q <= '0;
      filt_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q <= state_d;
      dwell_q <= dwell_d;
      filt_q  <= filt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.seq_done  = done_q;
  assign bus.busy      = busy_q;

`ifdef RST_SEQ_WDT_EN
  localparam int            WW      = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WDT_MAX = WW'(TIMEOUT);

  logic [WW-1:0] wdt_q, wdt_d;
  logic          err_q, err_d;

  // Counts time spent waiting for lock; sequencing is not gated by the error.
  always_comb begin
    wdt_d = wdt_q;
    err_d = err_q;
    if (bus.sw_rst_req) begin
      wdt_d = '0;
      err_d = 1'b0;
    end else if (state_d == RELEASE && state_q != RELEASE) begin
      wdt_d = '0;
    end else if ((state_q == HOLD || state_q == FILTER) && wdt_q != WDT_MAX) begin
      wdt_d = wdt_q + WW'(1);
      if (wdt_d == WDT_MAX) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q | !PARAM_OK;
`else
  assign bus.err_o = !PARAM_OK;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl with default parameters: a vector table
// for the nominal run and software abort, plus hand-written corner sequences.
module tb_rst_seq_ctrl;

  localparam int NUM_RST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rst_seq_ctrl_if #(.NUM_RST(NUM_RST)) bus ();

  rst_seq_ctrl #(
    .NUM_RST   (NUM_RST),
    .GAP_CYCLES(16),
    .LOCK_FILT (8),
    .TIMEOUT   (1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         n;
    logic       lock;
    logic       sw;
    logic [3:0] rst_n;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rn, input logic done,
                            input logic busy);
    check({tag, ".rst_n_out"}, 32'(bus.rst_n_out), 32'(rn));
    check({tag, ".seq_done"},  32'(bus.seq_done),  32'(done));
    check({tag, ".busy"},      32'(bus.busy),      32'(busy));
    check({tag, ".err_o"},     32'(bus.err_o),     32'(0));
  endtask

  // Advance n edges; outputs are sampled 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sw_rst_req is applied on the first of the n edges only.
  task automatic run(input int n, input logic lock, input logic sw);
    bus.lock_i     = lock;
    bus.sw_rst_req = sw;
    tick(1);
    bus.sw_rst_req = 1'b0;
    if (n > 1) tick(n - 1);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.sw_rst_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.lock_i     = 1'b1;
    bus.sw_rst_req = 1'b0;

    // Nominal release timing, a hold in DONE, then a software abort in DONE
    // (abort edge = 109) with the sequence re-timed from that edge.
    vecs[0]  = '{39, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[1]  = '{1,  1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    vecs[2]  = '{15, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    vecs[3]  = '{1,  1'b1, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[4]  = '{15, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[5]  = '{1,  1'b1, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[6]  = '{15, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[7]  = '{1,  1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
    vecs[8]  = '{20, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
    vecs[9]  = '{1,  1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[10] = '{39, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[11] = '{1,  1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    vecs[12] = '{15, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1};
    vecs[13] = '{1,  1'b1, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[14] = '{31, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[15] = '{1,  1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
    vecs[16] = '{1,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[17] = '{5,  1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};

    do_reset();
    check_outs("reset", 4'b0000, 1'b0, 1'b1);

    for (int i = 0; i < 18; i++) begin
      run(vecs[i].n, vecs[i].lock, vecs[i].sw);
      check_outs($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].done, vecs[i].busy);
    end

    // One-cycle lock glitch in FILTER at edge 20: bit 0 at 20+8+16 = 44.
    do_reset();
    run(19, 1'b1, 1'b0);
    run(1,  1'b0, 1'b0);
    check_outs("glitch@20", 4'b0000, 1'b0, 1'b1);
    run(23, 1'b1, 1'b0);
    check_outs("glitch@43", 4'b0000, 1'b0, 1'b1);
    run(1,  1'b1, 1'b0);
    check_outs("glitch@44", 4'b0001, 1'b0, 1'b1);

    // Lock lost at edge 61 with bits 0,1 out; full restart from that edge.
    do_reset();
    run(60, 1'b1, 1'b0);
    check_outs("drop@60", 4'b0011, 1'b0, 1'b1);
    run(1,  1'b0, 1'b0);
    check_outs("drop@61", 4'b0000, 1'b0, 1'b1);
    run(39, 1'b1, 1'b0);
    check_outs("drop@100", 4'b0000, 1'b0, 1'b1);
    run(1,  1'b1, 1'b0);
    check_outs("drop@101", 4'b0001, 1'b0, 1'b1);
    run(9,  1'b1, 1'b0);
    check_outs("drop@110", 4'b0001, 1'b0, 1'b1);

    // rst asserted mid-RELEASE, then a clean restart from edge 1.
    rst = 1'b1;
    tick(1);
    check_outs("rst_mid", 4'b0000, 1'b0, 1'b1);
    rst = 1'b0;
    run(39, 1'b1, 1'b0);
    check_outs("rst_mid@39", 4'b0000, 1'b0, 1'b1);
    run(1,  1'b1, 1'b0);
    check_outs("rst_mid@40", 4'b0001, 1'b0, 1'b1);

    // Software request in HOLD at edge 10 restarts the dwell: bit 0 at 50.
    do_reset();
    run(9,  1'b1, 1'b0);
    run(1,  1'b1, 1'b1);
    check_outs("swhold@10", 4'b0000, 1'b0, 1'b1);
    run(39, 1'b1, 1'b0);
    check_outs("swhold@49", 4'b0000, 1'b0, 1'b1);
    run(1,  1'b1, 1'b0);
    check_outs("swhold@50", 4'b0001, 1'b0, 1'b1);

    // Lock absent past the dwell: lock at edge 31 starts the filter, bit 0 at 54.
    do_reset();
    run(30, 1'b0, 1'b0);
    check_outs("latelock@30", 4'b0000, 1'b0, 1'b1);
    run(23, 1'b1, 1'b0);
    check_outs("latelock@53", 4'b0000, 1'b0, 1'b1);
    run(1,  1'b1, 1'b0);
    check_outs("latelock@54", 4'b0001, 1'b0, 1'b1);

    // Watchdog with lock held low from reset.
    do_reset();
`ifdef RST_SEQ_WDT_EN
    run(1023, 1'b0, 1'b0);
    check("wdt@1023", 32'(bus.err_o), 32'(0));
    run(1, 1'b0, 1'b0);
    check("wdt@1024", 32'(bus.err_o), 32'(1));
    run(6, 1'b0, 1'b0);
    check("wdt_sticky", 32'(bus.err_o), 32'(1));
    run(1, 1'b0, 1'b1);
    check("wdt_swclr", 32'(bus.err_o), 32'(0));
`else
    run(1023, 1'b0, 1'b0);
    check("nowdt@1023", 32'(bus.err_o), 32'(0));
    run(7, 1'b0, 1'b0);
    check("nowdt@1030", 32'(bus.err_o), 32'(0));
`endif
    check("wdt_busy", 32'(bus.busy), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the synchronous-release reset network.
- Waits for a stable clock-lock indication, then releases NUM_RST active-low domain resets one at a time, bit 0 first, with a fixed gap between releases.
- Re-asserts all domain resets on lock loss or a software request, then re-runs the sequence.
- Sits between the clock source/PLL and the per-domain synchronous-release reset blocks.

Parameters:
NUM_RST, 4, number of sequenced reset outputs (1..16)
GAP_CYCLES, 16, minimum HOLD dwell and spacing between consecutive releases (>=2)
LOCK_FILT, 8, consecutive lock_i=1 samples required before sequencing (>=1)
TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  one clock; reset is synchronous and active-high
lock_i  input  1  clock-lock indication, synchronous to clk
sw_rst_req  input  1  single-cycle software re-reset request
rst_n_out  output  NUM_RST  domain resets, active-low, registered
seq_done  output  1  all domain resets released
busy  output  1  high in HOLD, FILTER or RELEASE
err_o  output  1  sticky watchdog error

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=HOLD; rst_n_out=0; seq_done=0; busy=1; err_o=0; all counters cleared.
- Edge numbering: edge 1 is the first rising edge with rst=0. All outputs are registered and change only on clk edges.
- States: HOLD, FILTER, RELEASE, DONE.
- HOLD:
  - rst_n_out all 0; dwell counter increments each edge.
  - On the edge where the dwell count reaches GAP_CYCLES and lock_i=1, go to FILTER.
  - If lock_i=0 at that point, stay in HOLD with the dwell satisfied.
- FILTER:
  - Counts consecutive edges with lock_i=1.
  - On the LOCK_FILT-th consecutive edge, go to RELEASE with idx=0 and gap counter=0.
  - lock_i=0 clears the count and returns to HOLD with the dwell satisfied, so no new GAP_CYCLES wait.
- RELEASE:
  - Gap counter counts 1..GAP_CYCLES.
  - On the GAP_CYCLES-th edge, set rst_n_out[idx]=1, increment idx and clear the gap counter.
  - On the same edge that releases bit NUM_RST-1, go to DONE, set seq_done=1 and set busy=0.
- DONE: hold all outputs; remain in DONE until an abort.
- Release order and stability:
  - Bits are released strictly in index order.
  - A released bit stays 1 until an abort.
  - No bit ever toggles 1→0→1 within one sequence.
- Abort:
  - Trigger: lock_i=0 in RELEASE/DONE, or sw_rst_req=1 in any state other than HOLD.
  - On the next edge: rst_n_out=0, seq_done=0, busy=1, state=HOLD, dwell counter cleared (full GAP_CYCLES dwell).
  - sw_rst_req while in HOLD restarts the dwell counter.
  - Simultaneous lock loss and sw_rst_req behave as a single abort.
- Nominal timing with defaults and lock_i held at 1:
  - rst_n_out[k] rises after edge 40+16k.
  - seq_done rises after edge 88.
- Counter widths are $clog2 of the respective limits plus 1. Counters saturate and never wrap.

Optional Feature:
Macro RST_SEQ_WDT_EN.
- Defined:
  - A watchdog counter increments on every edge in HOLD/FILTER and clears on entering RELEASE.
  - On reaching TIMEOUT, err_o=1 (sticky) and the counter saturates.
  - Sequencing continues normally while err_o=1.
  - err_o clears only on rst=1 or sw_rst_req=1.
- Not defined: err_o is tied to 0 and no watchdog logic is instantiated.

Test Plan:
- Defaults, lock_i=1 throughout, rst released → rst_n_out 4'b0001 after edge 40, 4'b0011 after 56, 4'b0111 after 72, 4'b1111 and seq_done=1, busy=0 after 88.
- lock_i pulses low for 1 cycle at edge 20 (in FILTER) → filter restarts; rst_n_out[0] rises after edge 20+8+16=44, no extra dwell.
- lock_i drops at edge 60 (bits 0,1 released) → rst_n_out=0 and busy=1 after edge 61; when lock_i returns, full 16-cycle dwell, 8-cycle filter, then the sequence restarts from bit 0.
- sw_rst_req pulse in DONE → all outputs 0 and seq_done=0 on next edge; the full sequence repeats with identical 40/56/72/88 spacing, measured from the abort edge.
- rst asserted mid-RELEASE → all outputs return to reset values on that edge; sequence restarts from edge 1 after rst release.
- With RST_SEQ_WDT_EN, TIMEOUT=1024, lock_i=0 → err_o=1 after edge 1024 and stays high; a sw_rst_req pulse clears it. Without the macro, err_o=0 throughout.
